// File: rtl/stereolbm_round_pkg.sv
// Shared definitions for the disparity-product round/saturate stage.
//   PROD_W / OUT_W : default multiplier product width and result width
//   sat_max/sat_min: saturation bounds of a w-bit signed result, sized to
//                    hold a sign-extended product plus one guard bit
//   fifo_entry_t   : one output FIFO entry; carries the saturation flag only
//                    when STEREOLBM_SAT_FLAG_EN is defined
// The entry data field is sized by OUT_W, so a top-level OUT_WIDTH override
// must be matched here.
package stereolbm_round_pkg;

  localparam int PROD_W = 65;
  localparam int OUT_W  = 16;

  typedef struct packed {
    logic signed [OUT_W-1:0] data;
`ifdef STEREOLBM_SAT_FLAG_EN
    logic                    sat;
`endif
  } fifo_entry_t;

  function automatic logic signed [PROD_W:0] sat_max(input int w);
    return (PROD_W+1)'((longint'(1) <<< (w - 1)) - longint'(1));
  endfunction

  function automatic logic signed [PROD_W:0] sat_min(input int w);
    return (PROD_W+1)'(-(longint'(1) <<< (w - 1)));
  endfunction

endpackage

// File: rtl/stereolbm_skid_fifo.sv
// Small synchronous FIFO with a registered head.
//   clk, reset : clock, synchronous active-high reset
//   push       : write wr_data (never asserted when full unless pop is too)
//   wr_data    : entry to store
//   pop        : consume the head (only asserted when not empty)
//   rd_data    : registered copy of the oldest entry, stable until popped
//   full/empty : occupancy flags (count has DEPTH+1 states)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module stereolbm_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [CNT_W-1:0] count;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_next = rd_ptr + AW'(1);

  // NOTE: storage has no reset; validity comes from count/pointers, and a
  // resettable array would cost a reset path on every bit for no benefit.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_next;
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      // Head register: refill from storage when something is behind the
      // popped entry, otherwise take the incoming word directly. When full,
      // the slot being overwritten is the popped one, already in rd_data.
      if (pop) begin
        if (count > CNT_W'(1)) rd_data <= mem[rd_next];
        else if (push)         rd_data <= wr_data;
      end else if (push && empty) begin
        rd_data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/stereolbm_prod_round_sat.sv
// Consumer of the signed disparity-scaling multiplier product.
//   clk, reset : clock, synchronous active-high reset
//   s_valid    : operand pair presented to the multiplier inputs
//   s_ready    : equals mul_ce; operands accepted on s_valid && s_ready
//   mul_ce     : clock enable for every multiplier register stage
//   mul_dout   : product, valid MUL_LATENCY ce-cycles after acceptance
//   m_valid/m_ready/m_data : rounded, saturated result stream
// Optional STEREOLBM_SAT_FLAG_EN adds m_sat (entry was saturated) and
// sat_cnt (saturated pushes, sticky at 0xFFFF).
// The product is rounded half toward +inf at FRAC_BITS, saturated to
// OUT_WIDTH signed, registered once, then buffered in the output FIFO.
module stereolbm_prod_round_sat
  import stereolbm_round_pkg::*;
#(
  parameter int PROD_WIDTH  = PROD_W,
  parameter int MUL_LATENCY = 1,
  parameter int FRAC_BITS   = 32,
  parameter int OUT_WIDTH   = OUT_W,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         mul_ce,
  input  logic signed [PROD_WIDTH-1:0] mul_dout,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [OUT_WIDTH-1:0]  m_data
`ifdef STEREOLBM_SAT_FLAG_EN
  ,
  output logic                         m_sat,
  output logic [15:0]                  sat_cnt
`endif
);

  localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [PROD_WIDTH:0] RND_ADD =
    (FRAC_BITS > 0) ? ((PROD_WIDTH+1)'(1) <<< RND_SH) : '0;
  localparam logic signed [PROD_WIDTH:0] Q_MAX = sat_max(OUT_WIDTH);
  localparam logic signed [PROD_WIDTH:0] Q_MIN = sat_min(OUT_WIDTH);

  logic [MUL_LATENCY-1:0]      vld_pipe;
  logic                        rnd_vld;
  fifo_entry_t                 rnd_entry;
  fifo_entry_t                 r_entry;
  fifo_entry_t                 head;
  logic signed [PROD_WIDTH:0]  t;
  logic signed [PROD_WIDTH:0]  q;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        push;
  logic                        pop;

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  // Stall only when a real result is waiting on a full FIFO that is not
  // draining this cycle; a bubble in the rnd stage is overwritten instead.
  // Reset keeps ce high so the multiplier flushes while vld_pipe clears.
  assign mul_ce  = reset || !(rnd_vld && fifo_full && !pop);
  assign s_ready = mul_ce;
  assign push    = mul_ce && rnd_vld;
  assign m_data  = head.data;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    t       = $signed({mul_dout[PROD_WIDTH-1], mul_dout}) + RND_ADD;
    q       = t >>> FRAC_BITS;
    r_entry = '0;
    r_entry.data = q[OUT_WIDTH-1:0];
    if (q > Q_MAX) begin
      r_entry.data = Q_MAX[OUT_WIDTH-1:0];
`ifdef STEREOLBM_SAT_FLAG_EN
      r_entry.sat  = 1'b1;
`endif
    end else if (q < Q_MIN) begin
      r_entry.data = Q_MIN[OUT_WIDTH-1:0];
`ifdef STEREOLBM_SAT_FLAG_EN
      r_entry.sat  = 1'b1;
`endif
    end
  end

  // vld_pipe shadows the multiplier's ce-gated stages so stale multiplier
  // contents (e.g. after reset) are never mistaken for results.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      rnd_vld   <= 1'b0;
      rnd_entry <= '0;
    end else if (mul_ce) begin
      vld_pipe[0] <= s_valid;
      for (int i = 1; i < MUL_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      rnd_vld   <= vld_pipe[MUL_LATENCY-1];
      rnd_entry <= r_entry;
    end
  end

  stereolbm_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (rnd_entry),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef STEREOLBM_SAT_FLAG_EN
  assign m_sat = head.sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_cnt <= '0;
    end else if (push && rnd_entry.sat && sat_cnt != 16'hFFFF) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule
